spike_out_serializer: RTL and testbench

- Sits directly downstream of the SNN top level, in the sys_clk (CPU) domain.
- Consumes 250-bit spike frames from the SNN spike-out FIFO read port (fall-through, so data is valid whenever the FIFO is not empty).
- Serializes each frame into eight 32-bit words over a valid/ready interface for the CSR/bus bridge.
- Reports a per-frame spike popcount and a running count of delivered frames.

---
 rtl/spike_out_serializer_pkg.sv | 29 ++
 rtl/spike_out_serializer_popcount.sv | 21 ++
 rtl/spike_out_serializer.sv | 126 ++++++++++++
 tb/tb_spike_out_serializer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_out_serializer_pkg.sv
// Shared constants and state encoding for the spike-out serializer.
//
// Contents:
//   SPIKE_W  - width of one spike frame from the SNN spike-out FIFO
//   WORD_W   - width of one serialized output word
//   WORDS    - words per frame
//   BUF_W    - width of the frame buffer (WORDS*WORD_W)
//   PAD_W    - zero padding above the spike bits inside the buffer
//   IDX_W    - width of the word index
//   PCNT_W   - width of the per-frame spike popcount
//   state_t  - serializer states (IDLE, SEND)
package spike_out_serializer_pkg;

    localparam int SPIKE_W = 250;
    localparam int WORD_W  = 32;
    localparam int WORDS   = 8;
    localparam int BUF_W   = WORDS * WORD_W;
    localparam int PAD_W   = BUF_W - SPIKE_W;
    localparam int IDX_W   = 3;
    localparam int PCNT_W  = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/spike_out_serializer_popcount.sv
// Combinational population count of one spike frame.
//
// Ports:
//   spikes  in   SPIKE_W  spike frame (FIFO head data)
//   count   out  PCNT_W   number of set bits, 0..SPIKE_W
module spike_popcount
    import spike_out_serializer_pkg::*;
(
    input  logic [SPIKE_W-1:0] spikes,
    output logic [PCNT_W-1:0]  count
);

    // Plain adder chain; synthesis rebuilds it into a balanced tree.
    always_comb begin
        count = '0;
        for (int i = 0; i < SPIKE_W; i++) begin
            count = count + PCNT_W'(spikes[i]);
        end
    end

endmodule

// File: rtl/spike_out_serializer.sv
// Serializes spike frames from the SNN spike-out FIFO (fall-through read
// port) into 32-bit words on a valid/ready interface, and reports the spike
// popcount of the last captured frame plus a count of delivered frames.
//
// Ports:
//   sys_clk           in   1        block clock
//   sys_reset_n       in   1        asynchronous active-low reset
//   spike_out         in   SPIKE_W  FIFO head data, valid when not empty
//   spike_out_rempty  in   1        FIFO empty flag
//   spike_out_rinc    out  1        FIFO pop strobe
//   enable            in   1        permits capture of new frames
//   flush             in   1        synchronous abort / FIFO drain
//   word_rdata        out  WORD_W   current word
//   word_rvalid       out  1        word_rdata valid
//   word_rready       in   1        consumer accepts the word
//   word_idx          out  IDX_W    index of the current word
//   word_last         out  1        current word is the last of the frame
//   frame_spike_cnt   out  PCNT_W   popcount of the last captured frame
//   frame_cnt         out  CNT_W    frames fully delivered (wrapping)
//   busy              out  1        a frame is being sent
module spike_out_serializer
    import spike_out_serializer_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic               sys_clk,
    input  logic               sys_reset_n,
    input  logic [SPIKE_W-1:0] spike_out,
    input  logic               spike_out_rempty,
    output logic               spike_out_rinc,
    input  logic               enable,
    input  logic               flush,
    output logic [WORD_W-1:0]  word_rdata,
    output logic               word_rvalid,
    input  logic               word_rready,
    output logic [IDX_W-1:0]   word_idx,
    output logic               word_last,
    output logic [PCNT_W-1:0]  frame_spike_cnt,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               busy
);

    state_t             state;
    state_t             next_state;
    logic [BUF_W-1:0]   frame_buf;
    logic [PCNT_W-1:0]  popcount;
    logic               frame_ready;
    logic               handshake;
    logic               last_handshake;
    logic               capture;
    logic               drain;

    spike_popcount u_popcount (
        .spikes (spike_out),
        .count  (popcount)
    );

    // A new frame may be taken only when flush is not overriding enable.
    assign frame_ready    = enable && !flush && !spike_out_rempty;
    assign word_rvalid    = (state == SEND);
    assign busy           = word_rvalid;
    assign word_last      = word_rvalid && (word_idx == LAST_IDX);
    assign handshake      = word_rvalid && word_rready;
    assign last_handshake = handshake && word_last;
    assign word_rdata     = frame_buf[word_idx * WORD_W +: WORD_W];
    assign spike_out_rinc = capture || drain;

    // Next-state logic. A pop happens only on a capture or, in IDLE, on a
    // flush drain; in SEND the next frame is taken on the last-word handshake
    // so back-to-back frames have no idle cycle between them.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        drain      = 1'b0;
        case (state)
            IDLE: begin
                if (flush && !spike_out_rempty) begin
                    drain = 1'b1;
                end else if (frame_ready) begin
                    capture    = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (last_handshake) begin
                    if (frame_ready) begin
                        capture = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, frame buffer and counters. A flush in SEND drops the partial
    // frame without counting it, even if the consumer takes a word that cycle.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state           <= IDLE;
            frame_buf       <= '0;
            frame_spike_cnt <= '0;
            word_idx        <= '0;
            frame_cnt       <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                frame_buf       <= {{PAD_W{1'b0}}, spike_out};
                frame_spike_cnt <= popcount;
            end
            if (capture || flush || last_handshake) begin
                word_idx <= '0;
            end else if (handshake) begin
                word_idx <= word_idx + 1'b1;
            end
            if (last_handshake && !flush) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_out_serializer.sv
// Self-checking bench for spike_out_serializer.
//
// A queue models the fall-through spike-out FIFO. A monitor samples the DUT
// one time unit before each rising edge: on every capture pop it pushes the
// eight expected words of the popped frame to a scoreboard, and on every
// valid cycle it compares the presented word against the scoreboard head,
// popping it on a handshake. The directed sequence checks counters, pop
// timing, flush, enable and reset behaviour against bench-computed values.
module tb_spike_out_serializer;
    import spike_out_serializer_pkg::*;

    typedef struct {
        logic [WORD_W-1:0] data;
        logic [IDX_W-1:0]  idx;
    } word_t;

    logic               sys_clk = 1'b0;
    logic               sys_reset_n;
    logic [SPIKE_W-1:0] spike_out = '0;
    logic               spike_out_rempty = 1'b1;
    logic               spike_out_rinc;
    logic               enable;
    logic               flush;
    logic [WORD_W-1:0]  word_rdata;
    logic               word_rvalid;
    logic               word_rready;
    logic [IDX_W-1:0]   word_idx;
    logic               word_last;
    logic [PCNT_W-1:0]  frame_spike_cnt;
    logic [15:0]        frame_cnt;
    logic               busy;

    logic [SPIKE_W-1:0] fifo_q[$];
    word_t              exp_q[$];
    logic [WORD_W-1:0]  acc_q[$];
    int                 rinc_cyc[$];

    int n_checks       = 0;
    int n_pass         = 0;
    int cyc            = 0;
    int rinc_total     = 0;
    int valid_total    = 0;
    int last_valid_cyc = 0;

    spike_out_serializer #(.CNT_W(16)) dut (
        .sys_clk          (sys_clk),
        .sys_reset_n      (sys_reset_n),
        .spike_out        (spike_out),
        .spike_out_rempty (spike_out_rempty),
        .spike_out_rinc   (spike_out_rinc),
        .enable           (enable),
        .flush            (flush),
        .word_rdata       (word_rdata),
        .word_rvalid      (word_rvalid),
        .word_rready      (word_rready),
        .word_idx         (word_idx),
        .word_last        (word_last),
        .frame_spike_cnt  (frame_spike_cnt),
        .frame_cnt        (frame_cnt),
        .busy             (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks = n_checks + 1;
        assert (observed === expected) n_pass = n_pass + 1;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic en, input logic fl, input logic rdy);
        @(negedge sys_clk);
        enable      = en;
        flush       = fl;
        word_rready = rdy;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge sys_clk);
            done = !busy && (exp_q.size() == 0);
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic waitIdx(input string tag, input logic [IDX_W-1:0] target);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge sys_clk);
            done = busy && (word_idx == target);
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    function automatic logic [SPIKE_W-1:0] randFrame();
        logic [BUF_W-1:0] t;
        for (int i = 0; i < WORDS; i++) t[i*WORD_W +: WORD_W] = $urandom;
        return t[SPIKE_W-1:0];
    endfunction

    // FIFO model and scoreboard monitor.
    always begin
        logic             mon_rinc;
        logic             mon_flush;
        logic [BUF_W-1:0] cur;
        @(negedge sys_clk);
        #1;
        spike_out        = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        spike_out_rempty = (fifo_q.size() == 0);
        #3;
        cyc++;
        mon_rinc  = spike_out_rinc;
        mon_flush = flush;
        if (word_rvalid) begin
            valid_total++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rvalid", 32'(word_rvalid), 32'd0);
            end else begin
                checkOutput("word_rdata", word_rdata, exp_q[0].data);
                checkOutput("word_idx", 32'(word_idx), 32'(exp_q[0].idx));
                checkOutput("word_last", 32'(word_last), 32'(exp_q[0].idx == 3'd7));
                if (word_rready) begin
                    acc_q.push_back(word_rdata);
                    exp_q.delete(0);
                end
            end
        end
        if (mon_rinc) begin
            rinc_total++;
            rinc_cyc.push_back(cyc);
            checkOutput("rinc_while_empty", 32'(spike_out_rempty), 32'd0);
            if (busy) checkOutput("rinc_in_send", 32'(word_last && word_rready && !mon_flush), 32'd1);
            if (!mon_flush && fifo_q.size() > 0) begin
                cur = {{PAD_W{1'b0}}, fifo_q[0]};
                for (int w = 0; w < WORDS; w++)
                    exp_q.push_back('{data: cur[w*WORD_W +: WORD_W], idx: IDX_W'(w)});
            end
        end
        @(posedge sys_clk);
        #1;
        if (mon_rinc && fifo_q.size() > 0) fifo_q.delete(0);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [SPIKE_W-1:0] f;
        logic [SPIKE_W-1:0] fr [3];
        logic [WORD_W-1:0]  t1w [8];
        int r0, m0, v0;

        sys_reset_n = 1'b0;
        enable      = 1'b0;
        flush       = 1'b0;
        word_rready = 1'b0;
        #3;
        checkOutput("reset_rvalid", 32'(word_rvalid), 32'd0);
        checkOutput("reset_rdata", word_rdata, 32'd0);
        checkOutput("reset_rinc", 32'(spike_out_rinc), 32'd0);
        checkOutput("reset_idx", 32'(word_idx), 32'd0);
        checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("reset_spike_cnt", 32'(frame_spike_cnt), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        @(negedge sys_clk);
        sys_reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);

        // Single sparse frame: bits 0, 31, 32, 249.
        f = '0;
        f[0] = 1'b1; f[31] = 1'b1; f[32] = 1'b1; f[249] = 1'b1;
        t1w = '{32'h80000001, 32'h00000001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h02000000};
        @(negedge sys_clk);
        r0 = rinc_total;
        acc_q.delete();
        fifo_q.push_back(f);
        #2 checkOutput("t1_rvalid_before", 32'(word_rvalid), 32'd0);
        @(posedge sys_clk);
        #1 checkOutput("t1_rvalid_latency", 32'(word_rvalid), 32'd1);
        waitIdle("t1_done", 40);
        checkOutput("t1_word_count", 32'(acc_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) checkOutput("t1_word", acc_q[i], t1w[i]);
        checkOutput("t1_spike_cnt", 32'(frame_spike_cnt), 32'd4);
        checkOutput("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        checkOutput("t1_rinc_pulses", 32'(rinc_total - r0), 32'd1);

        // Three queued frames back to back.
        @(negedge sys_clk);
        r0 = rinc_total;
        m0 = rinc_cyc.size();
        v0 = valid_total;
        for (int i = 0; i < 3; i++) begin
            fr[i] = randFrame();
            fifo_q.push_back(fr[i]);
        end
        @(posedge sys_clk);
        #1;
        waitIdle("t2_done", 60);
        checkOutput("t2_rinc_pulses", 32'(rinc_total - r0), 32'd3);
        checkOutput("t2_rinc_gap1", 32'(rinc_cyc[m0+1] - rinc_cyc[m0]), 32'd8);
        checkOutput("t2_rinc_gap2", 32'(rinc_cyc[m0+2] - rinc_cyc[m0]), 32'd16);
        checkOutput("t2_valid_cycles", 32'(valid_total - v0), 32'd24);
        checkOutput("t2_no_bubble", 32'(last_valid_cyc - rinc_cyc[m0]), 32'd24);
        checkOutput("t2_frame_cnt", 32'(frame_cnt), 32'd4);
        checkOutput("t2_spike_cnt", 32'(frame_spike_cnt), 32'($countones(fr[2])));

        // Consumer stalls: ready pattern 1,0,random,1 per group of four cycles.
        @(negedge sys_clk);
        fifo_q.push_back(randFrame());
        @(posedge sys_clk);
        #1;
        begin
            bit done;
            done = 1'b0;
            for (int k = 0; k < 64 && !done; k++) begin
                @(negedge sys_clk);
                if (!busy) begin
                    done = 1'b1;
                end else begin
                    checkOutput("t3_frame_cnt_hold", 32'(frame_cnt), 32'd4);
                    case (k % 4)
                        0, 3:    word_rready = 1'b1;
                        1:       word_rready = 1'b0;
                        default: word_rready = 1'($urandom_range(0, 1));
                    endcase
                end
            end
            checkOutput("t3_done", 32'(done), 32'd1);
        end
        checkOutput("t3_frame_cnt", 32'(frame_cnt), 32'd5);
        word_rready = 1'b1;

        // Flush at word 3, then drain the two remaining entries.
        @(negedge sys_clk);
        r0 = rinc_total;
        for (int i = 0; i < 3; i++) fifo_q.push_back(randFrame());
        waitIdx("t4_reach_idx3", 3'd3);
        flush = 1'b1;
        @(posedge sys_clk);
        #1;
        checkOutput("t4_rvalid_after_flush", 32'(word_rvalid), 32'd0);
        checkOutput("t4_busy_after_flush", 32'(busy), 32'd0);
        checkOutput("t4_frame_cnt", 32'(frame_cnt), 32'd5);
        v0 = valid_total;
        @(negedge sys_clk);
        exp_q.delete();
        repeat (3) @(negedge sys_clk);
        checkOutput("t4_rinc_pulses", 32'(rinc_total - r0), 32'd3);
        checkOutput("t4_drain_consecutive", 32'(rinc_cyc[rinc_cyc.size()-1] - rinc_cyc[rinc_cyc.size()-2]), 32'd1);
        checkOutput("t4_fifo_empty", 32'(fifo_q.size()), 32'd0);
        checkOutput("t4_no_words", 32'(valid_total - v0), 32'd0);
        flush = 1'b0;

        // enable low with data waiting, then enable dropped at word 5.
        @(negedge sys_clk);
        enable = 1'b0;
        r0 = rinc_total;
        fr[0] = randFrame();
        fifo_q.push_back(fr[0]);
        repeat (4) @(negedge sys_clk);
        checkOutput("t5_no_rinc", 32'(rinc_total - r0), 32'd0);
        checkOutput("t5_rvalid_idle", 32'(word_rvalid), 32'd0);
        fr[1] = randFrame();
        fifo_q.push_back(fr[1]);
        enable = 1'b1;
        waitIdx("t5_reach_idx5", 3'd5);
        enable = 1'b0;
        waitIdle("t5_done", 20);
        checkOutput("t5_frame_cnt", 32'(frame_cnt), 32'd6);
        checkOutput("t5_left_in_fifo", 32'(fifo_q.size()), 32'd1);
        checkOutput("t5_rinc_pulses", 32'(rinc_total - r0), 32'd1);
        checkOutput("t5_spike_cnt", 32'(frame_spike_cnt), 32'($countones(fr[0])));

        // Drain the leftover frame, then an all-ones frame.
        @(negedge sys_clk);
        flush = 1'b1;
        @(negedge sys_clk);
        flush = 1'b0;
        @(negedge sys_clk);
        checkOutput("t6_drain_empty", 32'(fifo_q.size()), 32'd0);
        checkOutput("t6_spike_cnt_hold", 32'(frame_spike_cnt), 32'($countones(fr[0])));
        acc_q.delete();
        fifo_q.push_back({SPIKE_W{1'b1}});
        enable = 1'b1;
        @(posedge sys_clk);
        #1;
        waitIdle("t6_done", 20);
        checkOutput("t6_spike_cnt", 32'(frame_spike_cnt), 32'd250);
        checkOutput("t6_word0", acc_q[0], 32'hFFFFFFFF);
        checkOutput("t6_word7", acc_q[7], 32'h03FFFFFF);
        checkOutput("t6_frame_cnt", 32'(frame_cnt), 32'd7);

        // Asynchronous reset mid-frame, then a fresh capture.
        @(negedge sys_clk);
        fifo_q.push_back(randFrame());
        waitIdx("t7_reach_idx4", 3'd4);
        #2;
        sys_reset_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("t7_reset_rvalid", 32'(word_rvalid), 32'd0);
        checkOutput("t7_reset_idx", 32'(word_idx), 32'd0);
        checkOutput("t7_reset_rdata", word_rdata, 32'd0);
        checkOutput("t7_reset_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("t7_reset_spike_cnt", 32'(frame_spike_cnt), 32'd0);
        checkOutput("t7_reset_busy", 32'(busy), 32'd0);
        checkOutput("t7_reset_rinc", 32'(spike_out_rinc), 32'd0);
        @(negedge sys_clk);
        sys_reset_n = 1'b1;
        fifo_q.push_back(randFrame());
        @(posedge sys_clk);
        #1;
        checkOutput("t7_restart_idx", 32'(word_idx), 32'd0);
        checkOutput("t7_restart_rvalid", 32'(word_rvalid), 32'd1);
        waitIdle("t7_done", 20);
        checkOutput("t7_frame_cnt", 32'(frame_cnt), 32'd1);

        repeat (2) @(negedge sys_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
